// File: rtl/rca_writeback_sequencer_if.sv
// rca_writeback_sequencer_if
// Bundles the RCA channel side (bundle presentation and acceptance) and the
// register-file side (write ports, retire pulse, occupancy) of the writeback
// sequencer into one interface.
//   slave  : the sequencer view (consumes bundles, drives write ports)
//   master : the environment view (RCA channels + register file)
// Ports carried:
//   ch_done/ch_id/ch_rd_addr/ch_rd_data/ch_rd_mask -> bundle from each channel
//   ch_ack                                         <- bundle accepted
//   drain_en                                       -> register file ready
//   wr_valid/wr_addr/wr_data/wr_id                 <- write ports
//   retired/retired_id                             <- bundle completion
//   fifo_count                                     <- per-channel occupancy
interface rca_writeback_sequencer_if #(
  parameter int NUM_RCA_CHANNELS   = 2,
  parameter int RESULTS_PER_BUNDLE = 4,
  parameter int WRITE_PORTS        = 2,
  parameter int FIFO_DEPTH         = 4,
  parameter int XLEN               = 32,
  parameter int ID_WIDTH           = 3
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_RCA_CHANNELS-1:0]                                   ch_done;
  logic [NUM_RCA_CHANNELS-1:0][ID_WIDTH-1:0]                     ch_id;
  logic [NUM_RCA_CHANNELS-1:0][RESULTS_PER_BUNDLE-1:0][4:0]      ch_rd_addr;
  logic [NUM_RCA_CHANNELS-1:0][RESULTS_PER_BUNDLE-1:0][XLEN-1:0] ch_rd_data;
  logic [NUM_RCA_CHANNELS-1:0][RESULTS_PER_BUNDLE-1:0]           ch_rd_mask;
  logic [NUM_RCA_CHANNELS-1:0]                                   ch_ack;
  logic                                                          drain_en;
  logic [WRITE_PORTS-1:0]                                        wr_valid;
  logic [WRITE_PORTS-1:0][4:0]                                   wr_addr;
  logic [WRITE_PORTS-1:0][XLEN-1:0]                              wr_data;
  logic [ID_WIDTH-1:0]                                           wr_id;
  logic                                                          retired;
  logic [ID_WIDTH-1:0]                                           retired_id;
  logic [NUM_RCA_CHANNELS-1:0][CNT_W-1:0]                        fifo_count;

  modport slave (
    input  ch_done, ch_id, ch_rd_addr, ch_rd_data, ch_rd_mask, drain_en,
    output ch_ack, wr_valid, wr_addr, wr_data, wr_id, retired, retired_id, fifo_count
  );

  modport master (
    output ch_done, ch_id, ch_rd_addr, ch_rd_data, ch_rd_mask, drain_en,
    input  ch_ack, wr_valid, wr_addr, wr_data, wr_id, retired, retired_id, fifo_count
  );
endinterface

// File: rtl/rca_writeback_sequencer.sv
// rca_writeback_sequencer
// Buffers multi-result writeback bundles from several RCA channels in
// per-channel FIFOs, picks a channel round-robin, and drains the selected
// bundle into WRITE_PORTS register-file write ports per cycle, pulsing
// retired with the bundle id together with its last writes.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - rca_writeback_sequencer_if.slave (channel side + write side)
module rca_writeback_sequencer #(
  parameter int NUM_RCA_CHANNELS   = 2,
  parameter int RESULTS_PER_BUNDLE = 4,
  parameter int WRITE_PORTS        = 2,
  parameter int FIFO_DEPTH         = 4,
  parameter int XLEN               = 32,
  parameter int ID_WIDTH           = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  rca_writeback_sequencer_if.slave  bus
);
  localparam int N     = NUM_RCA_CHANNELS;
  localparam int R     = RESULTS_PER_BUNDLE;
  localparam int W     = WRITE_PORTS;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_e;

  // Per-channel bundle storage
  logic [ID_WIDTH-1:0]         id_mem_q   [N][FIFO_DEPTH];
  logic [ID_WIDTH-1:0]         id_mem_d   [N][FIFO_DEPTH];
  logic [R-1:0][4:0]           addr_mem_q [N][FIFO_DEPTH];
  logic [R-1:0][4:0]           addr_mem_d [N][FIFO_DEPTH];
  logic [R-1:0][XLEN-1:0]      data_mem_q [N][FIFO_DEPTH];
  logic [R-1:0][XLEN-1:0]      data_mem_d [N][FIFO_DEPTH];
  logic [R-1:0]                mask_mem_q [N][FIFO_DEPTH];
  logic [R-1:0]                mask_mem_d [N][FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q [N], wr_ptr_d [N];
  logic [PTR_W-1:0]            rd_ptr_q [N], rd_ptr_d [N];
  logic [CNT_W-1:0]            count_q  [N], count_d  [N];

  // Sequencer state
  state_e                      state_q, state_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [SEL_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [R-1:0]                rem_mask_q, rem_mask_d;

  // Combinational helpers
  logic [N-1:0]                full, empty, ack, pop;
  logic                        pick_found;
  logic [SEL_W-1:0]            pick_ch, cand;
  logic [ID_WIDTH-1:0]         head_id;
  logic [R-1:0][4:0]           head_addr;
  logic [R-1:0][XLEN-1:0]      head_data;
  logic                        drain_fire, retire;
  logic [R-1:0]                rem_next;
  int                          rank;
  logic                        port_used [W];
  logic [4:0]                  port_addr [W];
  logic [XLEN-1:0]             port_data [W];
  logic [W-1:0]                port_valid;

  // Occupancy flags and acceptance; a full FIFO refuses even when popping.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      full[c]  = (count_q[c] == CNT_W'(FIFO_DEPTH));
      empty[c] = (count_q[c] == {CNT_W{1'b0}});
      ack[c]   = bus.ch_done[c] & ~full[c] & ~rst;
    end
  end

  // Round-robin pick: first non-empty channel at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = {SEL_W{1'b0}};
    cand       = {SEL_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      cand = SEL_W'((int'(rr_ptr_q) + i) % N);
      if (!pick_found && !empty[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Head entry of the selected channel.
  always_comb begin
    head_id   = id_mem_q[sel_q][rd_ptr_q[sel_q]];
    head_addr = addr_mem_q[sel_q][rd_ptr_q[sel_q]];
    head_data = data_mem_q[sel_q][rd_ptr_q[sel_q]];
  end

  // Slot-to-port mapping: the k-th remaining set bit (ascending) goes to
  // port k when k < W; everything mapped is cleared from the mask.
  always_comb begin
    drain_fire = (state_q == S_DRAIN) && bus.drain_en;
    rank       = 0;
    rem_next   = rem_mask_q;
    for (int p = 0; p < W; p++) begin
      port_used[p] = 1'b0;
      port_addr[p] = 5'd0;
      port_data[p] = {XLEN{1'b0}};
    end
    for (int j = 0; j < R; j++) begin
      for (int p = 0; p < W; p++) begin
        if (drain_fire && rem_mask_q[j] && (rank == p)) begin
          port_used[p] = 1'b1;
          port_addr[p] = head_addr[j];
          port_data[p] = head_data[j];
          rem_next[j]  = 1'b0;
        end else begin
          port_used[p] = port_used[p];
        end
      end
      rank = rank + (rem_mask_q[j] ? 1 : 0);
    end
  end

  // Write enables: r0 writes are dropped, and when two ports target the same
  // register in one cycle only the higher port (later result) writes.
  always_comb begin
    for (int p = 0; p < W; p++) begin
      port_valid[p] = port_used[p] && (port_addr[p] != 5'd0);
      for (int q = p + 1; q < W; q++) begin
        if (port_used[q] && (port_addr[q] == port_addr[p])) begin
          port_valid[p] = 1'b0;
        end else begin
          port_valid[p] = port_valid[p];
        end
      end
    end
  end

  // Sequencer FSM next-state, retire and pop decisions.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    rem_mask_d = rem_mask_q;
    retire     = 1'b0;
    pop        = {N{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_DRAIN;
          sel_d      = pick_ch;
          rem_mask_d = mask_mem_q[pick_ch][rd_ptr_q[pick_ch]];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.drain_en) begin
          rem_mask_d = rem_next;
          if (rem_next == {R{1'b0}}) begin
            retire     = 1'b1;
            pop[sel_q] = 1'b1;
            rr_ptr_d   = (sel_q == SEL_W'(N - 1)) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1);
            state_d    = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO push/pop bookkeeping.
  always_comb begin
    id_mem_d   = id_mem_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    mask_mem_d = mask_mem_q;
    for (int c = 0; c < N; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(ack[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
      count_d[c]  = count_q[c] + CNT_W'(ack[c]) - CNT_W'(pop[c]);
      if (ack[c]) begin
        id_mem_d[c][wr_ptr_q[c]]   = bus.ch_id[c];
        addr_mem_d[c][wr_ptr_q[c]] = bus.ch_rd_addr[c];
        data_mem_d[c][wr_ptr_q[c]] = bus.ch_rd_data[c];
        mask_mem_d[c][wr_ptr_q[c]] = bus.ch_rd_mask[c];
      end else begin
        id_mem_d[c][wr_ptr_q[c]] = id_mem_q[c][wr_ptr_q[c]];
      end
    end
  end

  // Output drive.
  always_comb begin
    bus.ch_ack     = ack;
    bus.wr_valid   = port_valid;
    for (int p = 0; p < W; p++) begin
      bus.wr_addr[p] = port_addr[p];
      bus.wr_data[p] = port_data[p];
    end
    bus.wr_id      = (state_q == S_DRAIN) ? head_id : {ID_WIDTH{1'b0}};
    bus.retired    = retire;
    bus.retired_id = retire ? head_id : {ID_WIDTH{1'b0}};
    for (int c = 0; c < N; c++) begin
      bus.fifo_count[c] = count_q[c];
    end
  end

  // State registers; bundle storage needs no reset since pointers gate it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= {SEL_W{1'b0}};
      rr_ptr_q   <= {SEL_W{1'b0}};
      rem_mask_q <= {R{1'b0}};
      for (int c = 0; c < N; c++) begin
        wr_ptr_q[c] <= {PTR_W{1'b0}};
        rd_ptr_q[c] <= {PTR_W{1'b0}};
        count_q[c]  <= {CNT_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      rem_mask_q <= rem_mask_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      id_mem_q   <= id_mem_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      mask_mem_q <= mask_mem_d;
    end
  end
endmodule

// File: tb/tb_rca_writeback_sequencer.sv
// tb_rca_writeback_sequencer
// Directed bench for rca_writeback_sequencer (default parameters: 2 channels,
// 4 results per bundle, 2 write ports, FIFO depth 4). Inputs change 1 time
// unit after the rising edge; outputs are sampled 2 units later, mid-cycle.
module tb_rca_writeback_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  rca_writeback_sequencer_if bus ();

  rca_writeback_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [0:0] c, input logic [2:0] id, input logic [3:0] mask,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] a3, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3);
    bus.ch_id[c]         = id;
    bus.ch_rd_mask[c]    = mask;
    bus.ch_rd_addr[c][0] = a0;
    bus.ch_rd_addr[c][1] = a1;
    bus.ch_rd_addr[c][2] = a2;
    bus.ch_rd_addr[c][3] = a3;
    bus.ch_rd_data[c][0] = d0;
    bus.ch_rd_data[c][1] = d1;
    bus.ch_rd_data[c][2] = d2;
    bus.ch_rd_data[c][3] = d3;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.ch_done  = 2'b00;
    bus.drain_en = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.drain_en = 1'b1;
    load(1'b0, 3'd7, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'd3, 32'd4);
    load(1'b1, 3'd7, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'd3, 32'd4);
    bus.ch_done = 2'b11;
    cyc();
    cyc();
    #2;
    chk_cnt++; if (bus.ch_ack !== 2'b00) $display("FAIL rst_ack: got %b want 00", bus.ch_ack); else pass_cnt++;
    chk_cnt++; if (bus.wr_valid !== 2'b00) $display("FAIL rst_wr_valid: got %b want 00", bus.wr_valid); else pass_cnt++;
    chk_cnt++; if (bus.retired !== 1'b0) $display("FAIL rst_retired: got %b want 0", bus.retired); else pass_cnt++;
    chk_cnt++; if (bus.fifo_count !== 6'd0) $display("FAIL rst_fifo_count: got %h want 0", bus.fifo_count); else pass_cnt++;
    chk_cnt++; if ({bus.wr_id, bus.retired_id} !== 6'd0) $display("FAIL rst_ids: got %h want 0", {bus.wr_id, bus.retired_id}); else pass_cnt++;
    bus.ch_done  = 2'b00;
    bus.drain_en = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic_drain();
    do_reset();
    bus.drain_en = 1'b1;
    load(1'b0, 3'd3, 4'b1111, 5'd5, 5'd6, 5'd7, 5'd8, 32'hA, 32'hB, 32'hC, 32'hD);
    bus.ch_done = 2'b01;
    #2;
    chk_cnt++; if (bus.ch_ack !== 2'b01) $display("FAIL basic_ack: got %b want 01", bus.ch_ack); else pass_cnt++;
    cyc();
    bus.ch_done = 2'b00;
    #2;
    chk_cnt++; if (bus.fifo_count[0] !== 3'd1) $display("FAIL basic_count1: got %0d want 1", bus.fifo_count[0]); else pass_cnt++;
    chk_cnt++; if (bus.wr_valid !== 2'b00) $display("FAIL basic_latency: got %b want 00", bus.wr_valid); else pass_cnt++;
    cyc();
    #2;
    chk_cnt++; if (bus.wr_valid !== 2'b11) $display("FAIL basic_v1: got %b want 11", bus.wr_valid); else pass_cnt++;
    chk_cnt++; if ({bus.wr_addr[0], bus.wr_addr[1]} !== {5'd5, 5'd6}) $display("FAIL basic_a1: got %0d,%0d want 5,6", bus.wr_addr[0], bus.wr_addr[1]); else pass_cnt++;
    chk_cnt++; if ({bus.wr_data[0], bus.wr_data[1]} !== {32'hA, 32'hB}) $display("FAIL basic_d1: got %h,%h want a,b", bus.wr_data[0], bus.wr_data[1]); else pass_cnt++;
    chk_cnt++; if (bus.wr_id !== 3'd3) $display("FAIL basic_wr_id: got %0d want 3", bus.wr_id); else pass_cnt++;
    chk_cnt++; if (bus.retired !== 1'b0) $display("FAIL basic_early_retire: got %b want 0", bus.retired); else pass_cnt++;
    cyc();
    #2;
    chk_cnt++; if ({bus.wr_valid, bus.wr_addr[0], bus.wr_addr[1]} !== {2'b11, 5'd7, 5'd8}) $display("FAIL basic_a2: got %b %0d,%0d want 11 7,8", bus.wr_valid, bus.wr_addr[0], bus.wr_addr[1]); else pass_cnt++;
    chk_cnt++; if ({bus.wr_data[0], bus.wr_data[1]} !== {32'hC, 32'hD}) $display("FAIL basic_d2: got %h,%h want c,d", bus.wr_data[0], bus.wr_data[1]); else pass_cnt++;
    chk_cnt++; if ({bus.retired, bus.retired_id} !== {1'b1, 3'd3}) $display("FAIL basic_retire: got %b id %0d want 1 id 3", bus.retired, bus.retired_id); else pass_cnt++;
    cyc();
    #2;
    chk_cnt++; if (bus.fifo_count[0] !== 3'd0) $display("FAIL basic_count0: got %0d want 0", bus.fifo_count[0]); else pass_cnt++;
    chk_cnt++; if ({bus.retired, bus.wr_valid} !== 3'b000) $display("FAIL basic_quiet: got %b want 000", {bus.retired, bus.wr_valid}); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_id [4];
    int         ret_cyc [4];
    exp_id  = '{3'd1, 3'd2, 3'd4, 3'd6};
    ret_cyc = '{2, 4, 6, 8};
    do_reset();
    bus.drain_en = 1'b1;
    load(1'b0, 3'd1, 4'b0001, 5'd10, 5'd0, 5'd0, 5'd0, 32'd100, 32'd0, 32'd0, 32'd0);
    load(1'b1, 3'd2, 4'b0001, 5'd11, 5'd0, 5'd0, 5'd0, 32'd200, 32'd0, 32'd0, 32'd0);
    bus.ch_done = 2'b11;
    #2;
    chk_cnt++; if (bus.ch_ack !== 2'b11) $display("FAIL rr_ack_both: got %b want 11", bus.ch_ack); else pass_cnt++;
    cyc();
    load(1'b0, 3'd4, 4'b0001, 5'd12, 5'd0, 5'd0, 5'd0, 32'd300, 32'd0, 32'd0, 32'd0);
    load(1'b1, 3'd6, 4'b0001, 5'd13, 5'd0, 5'd0, 5'd0, 32'd400, 32'd0, 32'd0, 32'd0);
    cyc();
    bus.ch_done = 2'b00;
    #2;
    chk_cnt++; if (bus.fifo_count !== {3'd2, 3'd2}) $display("FAIL rr_counts: got %h want 12", bus.fifo_count); else pass_cnt++;
    for (int k = 2; k <= 9; k++) begin
      if (k > 2) begin
        cyc();
        #2;
      end
      for (int r = 0; r < 4; r++) begin
        if (k == ret_cyc[r]) begin
          chk_cnt++; if ({bus.retired, bus.retired_id, bus.wr_addr[0]} !== {1'b1, exp_id[r], 5'd10 + 5'(r)})
            $display("FAIL rr_order%0d: got ret %b id %0d addr %0d want 1 id %0d addr %0d", r, bus.retired, bus.retired_id, bus.wr_addr[0], exp_id[r], 10 + r); else pass_cnt++;
        end
      end
      if (k == 3) begin
        chk_cnt++; if (bus.retired !== 1'b0) $display("FAIL rr_gap: got %b want 0", bus.retired); else pass_cnt++;
      end
    end
    chk_cnt++; if (bus.fifo_count !== 6'd0) $display("FAIL rr_empty: got %h want 0", bus.fifo_count); else pass_cnt++;
  endtask

  task automatic test_dup_and_zero();
    do_reset();
    bus.drain_en = 1'b1;
    load(1'b0, 3'd5, 4'b1111, 5'd9, 5'd9, 5'd0, 5'd4, 32'h11, 32'h22, 32'h33, 32'h44);
    bus.ch_done = 2'b01;
    cyc();
    bus.ch_done = 2'b00;
    cyc();
    #2;
    chk_cnt++; if ({bus.wr_valid, bus.wr_addr[1], bus.wr_data[1]} !== {2'b10, 5'd9, 32'h22})
      $display("FAIL dup_c1: got %b r%0d %h want 10 r9 22", bus.wr_valid, bus.wr_addr[1], bus.wr_data[1]); else pass_cnt++;
    chk_cnt++; if (bus.retired !== 1'b0) $display("FAIL dup_early_retire: got %b want 0", bus.retired); else pass_cnt++;
    cyc();
    #2;
    chk_cnt++; if ({bus.wr_valid, bus.wr_addr[1], bus.wr_data[1]} !== {2'b10, 5'd4, 32'h44})
      $display("FAIL zero_c2: got %b r%0d %h want 10 r4 44", bus.wr_valid, bus.wr_addr[1], bus.wr_data[1]); else pass_cnt++;
    chk_cnt++; if ({bus.retired, bus.retired_id} !== {1'b1, 3'd5}) $display("FAIL dup_retire: got %b id %0d want 1 id 5", bus.retired, bus.retired_id); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    logic [2:0] got [4];
    int         n_ret;
    got   = '{3'd0, 3'd0, 3'd0, 3'd0};
    n_ret = 0;
    do_reset();
    bus.ch_done = 2'b10;
    for (int i = 0; i < 4; i++) begin
      load(1'b1, 3'(i + 1), 4'b0001, 5'(20 + i), 5'd0, 5'd0, 5'd0, 32'(i), 32'd0, 32'd0, 32'd0);
      #2;
      chk_cnt++; if (bus.ch_ack[1] !== 1'b1) $display("FAIL full_ack%0d: got %b want 1", i, bus.ch_ack[1]); else pass_cnt++;
      cyc();
    end
    load(1'b1, 3'd5, 4'b0001, 5'd25, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0, 32'd0);
    #2;
    chk_cnt++; if (bus.fifo_count[1] !== 3'd4) $display("FAIL full_count: got %0d want 4", bus.fifo_count[1]); else pass_cnt++;
    chk_cnt++; if (bus.ch_ack[1] !== 1'b0) $display("FAIL full_block: got %b want 0", bus.ch_ack[1]); else pass_cnt++;
    cyc();
    bus.drain_en = 1'b1;
    #2;
    chk_cnt++; if (bus.ch_ack[1] !== 1'b0) $display("FAIL full_block_on_pop: got %b want 0", bus.ch_ack[1]); else pass_cnt++;
    chk_cnt++; if ({bus.retired, bus.retired_id} !== {1'b1, 3'd1}) $display("FAIL full_first_retire: got %b id %0d want 1 id 1", bus.retired, bus.retired_id); else pass_cnt++;
    cyc();
    #2;
    chk_cnt++; if ({bus.ch_ack[1], bus.fifo_count[1]} !== {1'b1, 3'd3}) $display("FAIL full_reaccept: got ack %b cnt %0d want 1 3", bus.ch_ack[1], bus.fifo_count[1]); else pass_cnt++;
    cyc();
    bus.ch_done = 2'b00;
    for (int k = 0; k < 16; k++) begin
      #2;
      if (bus.retired === 1'b1) begin
        if (n_ret < 4) got[n_ret] = bus.retired_id;
        n_ret++;
      end
      cyc();
    end
    chk_cnt++; if (n_ret !== 4) $display("FAIL full_retire_count: got %0d want 4", n_ret); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (got[i] !== 3'(i + 2)) $display("FAIL full_order%0d: got %0d want %0d", i, got[i], i + 2); else pass_cnt++;
    end
    #2;
    chk_cnt++; if (bus.fifo_count[1] !== 3'd0) $display("FAIL full_drained: got %0d want 0", bus.fifo_count[1]); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    bus.drain_en = 1'b1;
    load(1'b0, 3'd6, 4'b1111, 5'd12, 5'd13, 5'd14, 5'd15, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    bus.ch_done = 2'b01;
    cyc();
    bus.ch_done = 2'b00;
    cyc();
    #2;
    chk_cnt++; if ({bus.wr_valid, bus.wr_addr[0], bus.wr_addr[1]} !== {2'b11, 5'd12, 5'd13}) $display("FAIL stall_pre: got %b %0d,%0d want 11 12,13", bus.wr_valid, bus.wr_addr[0], bus.wr_addr[1]); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.drain_en = 1'b0;
      #2;
      chk_cnt++; if ({bus.wr_valid, bus.retired} !== 3'b000) $display("FAIL stall_idle%0d: got %b want 000", k, {bus.wr_valid, bus.retired}); else pass_cnt++;
    end
    cyc();
    bus.drain_en = 1'b1;
    #2;
    chk_cnt++; if ({bus.wr_valid, bus.wr_addr[0], bus.wr_addr[1]} !== {2'b11, 5'd14, 5'd15}) $display("FAIL stall_resume_addr: got %b %0d,%0d want 11 14,15", bus.wr_valid, bus.wr_addr[0], bus.wr_addr[1]); else pass_cnt++;
    chk_cnt++; if ({bus.wr_data[0], bus.wr_data[1]} !== {32'hA2, 32'hA3}) $display("FAIL stall_resume_data: got %h,%h want a2,a3", bus.wr_data[0], bus.wr_data[1]); else pass_cnt++;
    chk_cnt++; if ({bus.retired, bus.retired_id} !== {1'b1, 3'd6}) $display("FAIL stall_retire: got %b id %0d want 1 id 6", bus.retired, bus.retired_id); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    seen = 0;
    do_reset();
    bus.drain_en = 1'b1;
    load(1'b0, 3'd1, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2, 32'd3, 32'd4);
    bus.ch_done = 2'b01;
    cyc();
    load(1'b0, 3'd2, 4'b1111, 5'd5, 5'd6, 5'd7, 5'd8, 32'd5, 32'd6, 32'd7, 32'd8);
    cyc();
    bus.ch_done = 2'b00;
    #2;
    chk_cnt++; if ({bus.wr_valid, bus.fifo_count[0]} !== {2'b11, 3'd2}) $display("FAIL rstmid_pre: got %b cnt %0d want 11 2", bus.wr_valid, bus.fifo_count[0]); else pass_cnt++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #2;
    chk_cnt++; if ({bus.wr_valid, bus.retired} !== 3'b000) $display("FAIL rstmid_outputs: got %b want 000", {bus.wr_valid, bus.retired}); else pass_cnt++;
    chk_cnt++; if (bus.fifo_count !== 6'd0) $display("FAIL rstmid_count: got %h want 0", bus.fifo_count); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      cyc();
      #2;
      if (bus.retired === 1'b1 || bus.wr_valid !== 2'b00) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL rstmid_no_retire: got %0d active cycles want 0", seen); else pass_cnt++;
  endtask

  initial begin
    bus.ch_done    = 2'b00;
    bus.ch_id      = '0;
    bus.ch_rd_addr = '0;
    bus.ch_rd_data = '0;
    bus.ch_rd_mask = '0;
    bus.drain_en   = 1'b0;
    test_reset();
    test_basic_drain();
    test_round_robin();
    test_dup_and_zero();
    test_fifo_full();
    test_stall();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/rca_writeback_sequencer.md
Name: rca_writeback_sequencer

Overview:
- Buffers multi-result writeback bundles from several RCA (reconfigurable custom accelerator) channels.
- Drains them into a fixed number of register-file write ports.
- Issues one retire per bundle.
- Sits between the RCA units and register_file/LVT logic; replaces the single-channel, all-results-at-once RCA commit path with arbitrated, rate-limited, in-order-per-channel writeback.

Parameters:
NUM_RCA_CHANNELS, 2, number of independent RCA writeback channels
RESULTS_PER_BUNDLE, 4, max destination registers per RCA instruction
WRITE_PORTS, 2, register-file write ports available per cycle
FIFO_DEPTH, 4, bundles buffered per channel (power of two, >=2)
XLEN, 32, data width
ID_WIDTH, 3, instruction id width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_done  in  [NUM_RCA_CHANNELS]  channel presents a bundle
ch_id  in  [NUM_RCA_CHANNELS][ID_WIDTH]  bundle instruction id
ch_rd_addr  in  [NUM_RCA_CHANNELS][RESULTS_PER_BUNDLE][5]  destination registers
ch_rd_data  in  [NUM_RCA_CHANNELS][RESULTS_PER_BUNDLE][XLEN]  result values
ch_rd_mask  in  [NUM_RCA_CHANNELS][RESULTS_PER_BUNDLE]  valid results
ch_ack  out  [NUM_RCA_CHANNELS]  bundle accepted this cycle
drain_en  in  1  register file may accept writes this cycle
wr_valid  out  [WRITE_PORTS]  write port active
wr_addr  out  [WRITE_PORTS][5]  write register address
wr_data  out  [WRITE_PORTS][XLEN]  write data
wr_id  out  ID_WIDTH  id of bundle being written
retired  out  1  one-cycle pulse: bundle fully written
retired_id  out  ID_WIDTH  id of retired bundle
fifo_count  out  [NUM_RCA_CHANNELS][$clog2(FIFO_DEPTH+1)]  per-channel occupancy

Behaviour:
- Reset (sync, active-high):
  - All FIFOs empty, FSM to IDLE, round-robin pointer to 0, partial bundle discarded.
  - wr_valid=0, retired=0, ch_ack=0, fifo_count=0, wr_id=retired_id=0.
- Acceptance:
  - ch_ack[c] = ch_done[c] & ~full[c] & ~rst, combinational.
  - Bundle {id, addr, data, mask} is pushed at that clock edge.
  - Full blocks ack even if the same FIFO pops that cycle.
  - Channels are accepted independently; all may push in the same cycle.
- FSM IDLE:
  - If any FIFO is non-empty, pick the first non-empty channel at or after rr_ptr (wrap-around).
  - Latch the remaining mask from that FIFO head and go to DRAIN.
  - The first write happens no earlier than the cycle after push (minimum push-to-write latency 1).
- FSM DRAIN, each cycle with drain_en=1:
  - Take the lowest-index remaining mask bits, up to WRITE_PORTS of them, and assign them in ascending order to ports 0..WRITE_PORTS-1.
  - Clear those bits. wr_id = head id.
  - Results with addr 0 are consumed (bit cleared, counts against port budget) but their wr_valid stays 0.
  - Same-cycle duplicate addresses: only the highest-index result drives wr_valid; lower ones are suppressed. Across cycles the later write naturally overwrites.
  - When the remaining mask becomes 0 this cycle:
    - Pulse retired with retired_id = head id in the same cycle as the last writes.
    - Pop the FIFO and set rr_ptr = selected channel + 1 (mod NUM_RCA_CHANNELS).
    - Return to IDLE. Back-to-back bundles therefore have a 1-cycle IDLE gap.
- DRAIN with drain_en=0: no writes, no mask change, retired=0, selection held.
- Empty-mask bundle: in the first DRAIN cycle with drain_en=1, no wr_valid and retired pulses.
- Cycles per bundle: max(1, ceil(popcount(mask)/WRITE_PORTS)) with drain_en held high.
- Ordering: bundles from one channel retire in push order. There is no ordering guarantee across channels.
- fifo_count: registered; +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- Width: the count is $clog2(FIFO_DEPTH+1) bits. Read and write pointers are $clog2(FIFO_DEPTH) bits with natural wrap.

Test Plan:
- Reset, then ch0 pushes id=3, mask=4'b1111, addr={5,6,7,8}, data={A,B,C,D}, drain_en=1 -> writes (5,A),(6,B) then (7,C),(8,D); retired with id=3 on the second write cycle; fifo_count[0] goes 1->0.
- ch0 id=1 and ch1 id=2 pushed in the same cycle, mask=4'b0001 each -> ch0 retires first, then after the IDLE gap ch1; a second round starts at ch1 (rr_ptr) if both non-empty.
- Bundle addr={9,9,0,4}, mask=4'b1111 -> cycle 1: only port1 writes r9 (index 1 wins); cycle 2: addr0 consumed silently, port1 writes r4; retired.
- FIFO_DEPTH=4: with drain_en=0, ch1 pushes 5 bundles back-to-back -> first 4 acked, fifo_count=4, 5th held with ch_ack=0 until a pop.
- Mid-DRAIN, drain_en=0 for 3 cycles -> outputs idle, remaining mask preserved; resume completes with the correct data.
- Assert rst during DRAIN with 2 bundles queued -> next cycle wr_valid=0, fifo_count=0, no retired pulse for the discarded bundles.
